alu_mul_seq: RTL and testbench
==============================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL provide port: clock  input  1  single clock; all registers update on rising edge.
REQ-002 The block SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL provide port: start  input  1  request pulse; sampled only in IDLE.
REQ-004 The block SHALL provide port: a  input  16  signed multiplicand, captured on an accepted start.
REQ-005 The block SHALL provide port: b  input  16  signed multiplier, captured on an accepted start.
REQ-006 The block SHALL provide port: busy  output  1  high in any state other than IDLE.
REQ-007 The block SHALL provide port: done  output  1  one-cycle pulse, high only in DONE.
REQ-008 The block SHALL provide port: product  output  16  low 16 bits of a*b; held until the next accepted start.
REQ-009 The block SHALL provide port: zr  output  1  high when product == 0.
REQ-010 The block SHALL provide port: ng  output  1  equal to product[15].

Function
REQ-011 The block SHALL compute products only through one shared Hack ALU instance, driving its zx,nx,zy,ny,f,no controls from the FSM.
REQ-012 The FSM SHALL have states IDLE, ADD, DBL and DONE.
REQ-013 In IDLE with start=1, the FSM SHALL capture mcand=a, mplier=b and acc=0, clear the bit counter, and move to ADD.
REQ-014 In ADD, the ALU SHALL be set to x+y (000010) with x=acc and y=mcand; acc SHALL load the ALU output only when mplier[0]=1; next state SHALL be DBL.
REQ-015 In DBL, the ALU SHALL be set to x+y with x=y=mcand; mcand SHALL load the ALU output; mplier SHALL shift right logically by 1; the counter SHALL increment.
REQ-016 From DBL, the FSM SHALL go to DONE when the counter was 15, else to ADD.
REQ-017 In DONE, the FSM SHALL assert done for exactly one cycle, load product from acc, and return to IDLE.
REQ-018 Latency SHALL be fixed: done SHALL be high in the 33rd cycle after the start-accept edge, after 32 ADD/DBL cycles.
REQ-019 Arithmetic SHALL wrap modulo 2^16; signed operands SHALL yield the correct two's-complement low 16 bits, with no overflow flag.
REQ-020 A start asserted while busy=1 SHALL be ignored, with no queueing.
REQ-021 zr and ng SHALL be combinational functions of the product register.
REQ-022 The ALU controls SHALL be held at 101010 (constant 0) in IDLE and DONE.

Reset
REQ-023 Reset SHALL force state=IDLE and clear busy, done, product, acc, mcand, mplier and the counter immediately, independent of clock; zr SHALL then read 1 and ng 0.
REQ-024 Reset mid-operation SHALL abort the operation without asserting done; the first start after reset release SHALL begin a fresh operation.

Configuration
REQ-025 With MUL_EARLY_EXIT_EN defined, DBL SHALL go to DONE as soon as the shifted mplier is zero.
REQ-026 Without MUL_EARLY_EXIT_EN, the fixed 16-iteration latency of REQ-018 SHALL apply, and results SHALL be identical in both builds.

Structure
REQ-027 A shared package alu_pkg SHALL hold the 6-bit ALU control constants (ADD=000010, ZERO=101010) and the 2-bit FSM state encodings.
REQ-028 The Hack ALU SHALL be the single instantiated sub-module, named ALU; all sequencing logic SHALL reside in alu_mul_seq.

Verification
REQ-029 The bench SHALL cover: a=3, b=5, one-cycle start -> busy=1 next cycle, done at cycle 33, product=15, zr=0, ng=0 (with MUL_EARLY_EXIT_EN: done at cycle 7).
REQ-030 The bench SHALL cover: a=-3, b=7 -> product=-21, ng=1, zr=0.
REQ-031 The bench SHALL cover: a=1234, b=0 -> product=0, zr=1, ng=0 (with MUL_EARLY_EXIT_EN: done at cycle 3).
REQ-032 The bench SHALL cover: a=300, b=300 -> product=24464, i.e. 90000 mod 65536.
REQ-033 The bench SHALL cover: start pulsed again at cycle 10 of a=9, b=15 -> ignored, product=135, exactly one done pulse.
REQ-034 The bench SHALL cover: reset asserted at cycle 12 of an operation -> busy=0 and product=0 at once, no done pulse; then a=2, b=-1 -> product=-2.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the sequential Hack-ALU multiplier:
//                6-bit ALU control words {zx,nx,zy,ny,f,no}, the 2-bit FSM
//                state encoding and datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int C_WIDTH     = 16;
  localparam int C_CNT_WIDTH = 4;

  // ALU control word, ordered {zx, nx, zy, ny, f, no}
  typedef logic [5:0] alu_ctrl_t;

  localparam alu_ctrl_t c_alu_add  = 6'b000010;  // out = x + y
  localparam alu_ctrl_t c_alu_zero = 6'b101010;  // out = 0

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DBL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/ALU.sv
// ============================================================================
//  Module      : ALU
//  Description : Combinational 16-bit Hack ALU.
//  Ports       : x, y              - 16-bit operands
//                zx,nx,zy,ny,f,no  - Hack control bits
//                out               - 16-bit result
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ALU
  import alu_pkg::*;
(
  input  logic [C_WIDTH-1:0] x,
  input  logic [C_WIDTH-1:0] y,
  input  logic               zx,
  input  logic               nx,
  input  logic               zy,
  input  logic               ny,
  input  logic               f,
  input  logic               no,
  output logic [C_WIDTH-1:0] out
);

  logic [C_WIDTH-1:0] w_x0;
  logic [C_WIDTH-1:0] w_x1;
  logic [C_WIDTH-1:0] w_y0;
  logic [C_WIDTH-1:0] w_y1;
  logic [C_WIDTH-1:0] w_fn;

  always_comb begin
    w_x0 = zx ? '0 : x;
    w_x1 = nx ? ~w_x0 : w_x0;
    w_y0 = zy ? '0 : y;
    w_y1 = ny ? ~w_y0 : w_y0;
    w_fn = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    out  = no ? ~w_fn : w_fn;
  end

endmodule : ALU

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
//  Module      : alu_mul_seq
//  Description : 16x16 -> 16 (low half) shift-and-add multiplier that does all
//                of its arithmetic through one shared Hack ALU. Each multiplier
//                bit costs two cycles: ADD (acc += mcand when the bit is set)
//                and DBL (mcand += mcand, mplier >>= 1).
//  Ports       : clock   - rising-edge clock
//                reset   - asynchronous active-high reset
//                start   - request pulse, sampled only in IDLE
//                a, b    - signed multiplicand / multiplier
//                busy    - high outside IDLE
//                done    - one-cycle pulse in DONE
//                product - low 16 bits of a*b, updated on leaving DONE
//                zr, ng  - product == 0 / product sign bit
//  Config      : MUL_EARLY_EXIT_EN - when defined, finish as soon as the
//                remaining multiplier bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq
  import alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [C_WIDTH-1:0] product,
  output logic               zr,
  output logic               ng
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [C_WIDTH-1:0]     r_acc;
  logic [C_WIDTH-1:0]     r_mcand;
  logic [C_WIDTH-1:0]     r_mplier;
  logic [C_CNT_WIDTH-1:0] r_cnt;
  logic [C_WIDTH-1:0]     r_product;

  alu_ctrl_t              w_ctrl;
  logic [C_WIDTH-1:0]     w_alu_x;
  logic [C_WIDTH-1:0]     w_alu_out;
  logic                   w_last_iter;

  // Last iteration: fixed count, or (optionally) nothing left to add.
`ifdef MUL_EARLY_EXIT_EN
  assign w_last_iter = (r_cnt == 4'd15) || (r_mplier[C_WIDTH-1:1] == '0);
`else
  assign w_last_iter = (r_cnt == 4'd15);
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and ALU steering
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = c_alu_zero;
    w_alu_x     = r_acc;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_ADD;
      end
      ST_ADD: begin
        w_ctrl      = c_alu_add;
        w_state_nxt = ST_DBL;
      end
      ST_DBL: begin
        // Doubling the multiplicand: both ALU inputs see mcand.
        w_ctrl      = c_alu_add;
        w_alu_x     = r_mcand;
        w_state_nxt = w_last_iter ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  ALU u_alu (
    .x   (w_alu_x),
    .y   (r_mcand),
    .zx  (w_ctrl[5]),
    .nx  (w_ctrl[4]),
    .zy  (w_ctrl[3]),
    .ny  (w_ctrl[2]),
    .f   (w_ctrl[1]),
    .no  (w_ctrl[0]),
    .out (w_alu_out)
  );

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_ADD: begin
          if (r_mplier[0]) r_acc <= w_alu_out;
        end
        ST_DBL: begin
          r_mcand  <= w_alu_out;
          r_mplier <= {1'b0, r_mplier[C_WIDTH-1:1]};
          r_cnt    <= r_cnt + 4'd1;
        end
        ST_DONE: begin
          r_product <= r_acc;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;
  assign zr      = (r_product == '0);
  assign ng      = r_product[C_WIDTH-1];

endmodule : alu_mul_seq

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
//  Module      : tb_alu_mul_seq
//  Description : Scoreboard bench for alu_mul_seq. The driver pushes the
//                expected product and latency for each accepted request; a
//                monitor pops and compares whenever done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mul_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        zr;
  logic        ng;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  typedef struct {
    logic [15:0] prod;
    int          lat;
    int          t0;
    string       tag;
  } exp_t;

  exp_t sb[$];

  alu_mul_seq dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zr      (zr),
    .ng      (ng)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ncyc <= ncyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: low 16 bits of the signed product; latency from multiplier bits.
  function automatic logic [15:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  function automatic int ref_lat(input logic [15:0] y);
`ifdef MUL_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < 16; i++) if (y[i]) n = i + 1;
    return 2 * n + 1;
`else
    return 33;
`endif
  endfunction

  // Monitor: compare on every done pulse; product is visible the cycle after.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_latency"}, ncyc - e.t0, e.lat);
          check({e.tag, "_busy_in_done"}, int'(busy), 1);
          @(negedge clock);
          check({e.tag, "_product"}, int'($signed(product)), int'($signed(e.prod)));
          check({e.tag, "_zr"}, int'(zr), int'(e.prod == 16'd0));
          check({e.tag, "_ng"}, int'(ng), int'(e.prod[15]));
          check({e.tag, "_done_one_cycle"}, int'(done), 0);
          check({e.tag, "_idle_after"}, int'(busy), 0);
        end
      end
    end
  end

  // Issue one request. extra_start_at / reset_at give the cycle (1 = first
  // cycle after accept) at which a stray start or a reset is injected; 0 = none.
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input int extra_start_at, input int reset_at);
    exp_t e;
    bit   finished;
    @(negedge clock);
    a = x;
    b = y;
    start = 1'b1;
    e.prod = ref_prod(x, y);
    e.lat  = ref_lat(y);
    e.t0   = ncyc;
    e.tag  = tag;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy_after_start"}, int'(busy), 1);
    finished = 1'b0;
    for (int c = 2; c < 80; c++) begin
      @(negedge clock);
      if (c == extra_start_at) begin
        a = 16'h7777;
        b = 16'h0003;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c == reset_at) begin
        #2 reset = 1'b1;
        #1;
        check({tag, "_rst_busy"}, int'(busy), 0);
        check({tag, "_rst_done"}, int'(done), 0);
        check({tag, "_rst_product"}, int'(product), 0);
        check({tag, "_rst_zr"}, int'(zr), 1);
        check({tag, "_rst_ng"}, int'(ng), 0);
        void'(sb.pop_back());
        @(negedge clock);
        reset = 1'b0;
        finished = 1'b1;
        break;
      end
      if (c > extra_start_at + 1 && sb.size() == 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!finished) begin
      check({tag, "_timeout"}, 1, 0);
      sb.delete();
    end
  endtask

  initial begin
    logic [15:0] rx, ry;
    int ign_at;
`ifdef MUL_EARLY_EXIT_EN
    ign_at = 4;
`else
    ign_at = 10;
`endif
    reset = 1'b1;
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_product", int'(product), 0);
    check("reset_zr", int'(zr), 1);
    check("reset_ng", int'(ng), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_op("3x5", 16'd3, 16'd5, 0, 0);
    run_op("m3x7", -16'sd3, 16'd7, 0, 0);
    run_op("1234x0", 16'd1234, 16'd0, 0, 0);
    run_op("300x300", 16'd300, 16'd300, 0, 0);
    run_op("9x15_ign", 16'd9, 16'd15, ign_at, 0);
    run_op("rst_abort", 16'd100, -16'sd5, 0, 12);
    run_op("2xm1", 16'd2, -16'sd1, 0, 0);
    run_op("min_x_min", 16'h8000, 16'h8000, 0, 0);
    run_op("m1xm1", 16'hFFFF, 16'hFFFF, 0, 0);

    for (int i = 0; i < 20; i++) begin
      rx = 16'($urandom);
      ry = (i % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      run_op("rand", rx, ry, 0, 0);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got %0d expected %0d", ncyc, 0);
    $fatal(1, "global timeout");
  end

endmodule : tb_alu_mul_seq

`default_nettype wire
